// File: rtl/matrix_entry_loader_pkg.sv
// Shared constants, state encoding and element addressing for the matrix
// entry loader and its row/column counter.
package matrix_entry_loader_pkg;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

  // Plain vector states keep the encoding readable by older tools.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DONE = 2'd2;

  // Bit offset of element (i,j) in the row-major packed matrix bus.
  function automatic logic [7:0] elem_offset(input logic [2:0] i, input logic [2:0] j);
    logic [7:0] idx;
    idx = 8'(i) * 8'(MAX_DIM) + 8'(j);
    return idx * 8'(ELEM_W);
  endfunction

endpackage

// File: rtl/matrix_entry_loader_rc_counter.sv
// Row/column position counter for the matrix entry loader. Columns wrap at
// dim_n and carry into the row; last_o flags the final (dim_m-1, dim_n-1) slot.
module matrix_entry_loader_rc_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       advance_i,
  input  logic [2:0] dim_m_i,
  input  logic [2:0] dim_n_i,
  output logic [2:0] row_o,
  output logic [2:0] col_o,
  output logic       last_o
);

  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;

  // Next position: clear wins, otherwise step the column and carry into the row.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == dim_n_i - 3'd1) begin
        col_d = '0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end
  end

  // Position registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == dim_m_i - 3'd1) && (col_q == dim_n_i - 3'd1);

endmodule

// File: rtl/matrix_entry_loader.sv
// Matrix entry loader: accepts elements one at a time and packs them
// row-major into the 5x5x8-bit matrix bus, then offers the result with a
// valid/ready handshake. Optional feature macro: ELEM_RANGE_CHECK_EN rejects
// elements larger than MAX_ELEM with an err pulse.
module matrix_entry_loader
  import matrix_entry_loader_pkg::state_t;
  import matrix_entry_loader_pkg::IDLE;
  import matrix_entry_loader_pkg::LOAD;
  import matrix_entry_loader_pkg::DONE;
  import matrix_entry_loader_pkg::MAT_W;
  import matrix_entry_loader_pkg::elem_offset;
#(
  parameter int MAX_DIM  = 5,
  parameter int ELEM_W   = 8,
  parameter int MAX_ELEM = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        m,
  input  logic [2:0]        n,
  input  logic              start,
  input  logic              abort,
  input  logic              elem_valid,
  input  logic [ELEM_W-1:0] elem_data,
  output logic              elem_ready,
  output logic              mat_valid,
  input  logic              mat_ready,
  output logic [MAT_W-1:0]  matrix,
  output logic [2:0]        dim_m,
  output logic [2:0]        dim_n,
  output logic [4:0]        elem_count,
  output logic              err
);

`ifdef ELEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [MAT_W-1:0] matrix_q, matrix_d;
  logic [2:0]       dim_m_q, dim_m_d;
  logic [2:0]       dim_n_q, dim_n_d;
  logic [4:0]       count_q, count_d;
  logic             mat_valid_q, mat_valid_d;
  logic             err_q, err_d;

  logic       dims_ok, accept, elem_bad, store, pos_clear, pos_last;
  logic [2:0] row, col;

  assign dims_ok    = (m != 3'd0) && (m <= 3'(MAX_DIM)) && (n != 3'd0) && (n <= 3'(MAX_DIM));
  assign elem_ready = (state_q == LOAD);
  assign elem_bad   = RANGE_CHECK && (elem_data > ELEM_W'(MAX_ELEM));
  // abort outranks a simultaneous element, which is simply dropped.
  assign accept     = elem_ready && elem_valid && !abort;
  assign store      = accept && !elem_bad;
  assign pos_clear  = ((state_q == IDLE) && start && dims_ok) || ((state_q == LOAD) && abort);

  matrix_entry_loader_rc_counter u_rc_counter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (pos_clear),
    .advance_i (store),
    .dim_m_i   (dim_m_q),
    .dim_n_i   (dim_n_q),
    .row_o     (row),
    .col_o     (col),
    .last_o    (pos_last)
  );

  // Load sequencing: dimension capture, element placement and handshake.
  always_comb begin
    state_d     = state_q;
    matrix_d    = matrix_q;
    dim_m_d     = dim_m_q;
    dim_n_d     = dim_n_q;
    count_d     = count_q;
    mat_valid_d = mat_valid_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (dims_ok) begin
            dim_m_d  = m;
            dim_n_d  = n;
            matrix_d = '0;
            count_d  = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort) begin
          matrix_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else if (accept) begin
          if (elem_bad) begin
            err_d = 1'b1;
          end else begin
            matrix_d[elem_offset(row, col) +: ELEM_W] = elem_data;
            count_d = count_q + 5'd1;
            if (pos_last) begin
              mat_valid_d = 1'b1;
              state_d     = DONE;
            end
          end
        end
      end
      DONE: begin
        if (mat_ready) begin
          mat_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the matrix is 200 plain flops, not a RAM, so it can be reset with everything else.
    if (reset) begin
      state_q     <= IDLE;
      matrix_q    <= '0;
      dim_m_q     <= '0;
      dim_n_q     <= '0;
      count_q     <= '0;
      mat_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      matrix_q    <= matrix_d;
      dim_m_q     <= dim_m_d;
      dim_n_q     <= dim_n_d;
      count_q     <= count_d;
      mat_valid_q <= mat_valid_d;
      err_q       <= err_d;
    end
  end

  assign matrix     = matrix_q;
  assign dim_m      = dim_m_q;
  assign dim_n      = dim_n_q;
  assign elem_count = count_q;
  assign mat_valid  = mat_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_matrix_entry_loader.sv
// Self-checking bench for matrix_entry_loader: a driver issues loads and pushes
// the expected finished matrix into a scoreboard; a monitor pops and compares
// each time the DUT presents a matrix.
module tb_matrix_entry_loader;

`ifdef ELEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   m, n;
  logic         start, abort, elem_valid, mat_ready;
  logic [7:0]   elem_data;
  logic         elem_ready, mat_valid, err;
  logic [199:0] matrix;
  logic [2:0]   dim_m, dim_n;
  logic [4:0]   elem_count;

  typedef struct {
    logic [199:0] mat;
    logic [4:0]   cnt;
    logic [2:0]   dm;
    logic [2:0]   dn;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  bit           taken  = 1'b0;
  logic [199:0] held_mat = '0;
  logic [2:0]   held_m = '0, held_n = '0;
  logic [7:0]   last_elem = '0;

  matrix_entry_loader dut (
    .clk        (clk),
    .reset      (reset),
    .m          (m),
    .n          (n),
    .start      (start),
    .abort      (abort),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_ready (elem_ready),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .matrix     (matrix),
    .dim_m      (dim_m),
    .dim_n      (dim_n),
    .elem_count (elem_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each newly presented matrix against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!mat_valid) begin
      taken = 1'b0;
    end else if (!taken) begin
      taken = 1'b1;
      if (sb_q.size() == 0) begin
        check("unexpected_matrix", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_matrix", matrix, e.mat);
        check("sb_elem_count", elem_count, e.cnt);
        check("sb_dim_m", dim_m, e.dm);
        check("sb_dim_n", dim_n, e.dn);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_elem_ready"}, elem_ready, 0);
    check({tag, "_mat_valid"}, mat_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_matrix"}, matrix, 0);
    check({tag, "_dim_m"}, dim_m, 0);
    check({tag, "_dim_n"}, dim_n, 0);
    check({tag, "_elem_count"}, elem_count, 0);
    held_mat = '0; held_m = '0; held_n = '0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_vals(tag);
  endtask

  // Start a load of mm x nn and feed elements until the matrix completes, or
  // until stop_after elements have been accepted (stop_after < 0: complete).
  // Values come from vals first, then random. Gap cycles carry a stray start
  // pulse that must be ignored while loading.
  task automatic run_load(input int mm, input int nn, input bit gaps,
                          input int vals[$], input int stop_after);
    logic [7:0]   grid [5][5];
    logic [199:0] packed_mat;
    int           k, idx, v, total;
    bit           bad;
    exp_t         e;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) grid[i][j] = '0;
    total = mm * nn;
    k = 0; idx = 0;
    m = 3'(mm); n = 3'(nn); start = 1'b1;
    step();
    start = 1'b0;
    check("start_elem_ready", elem_ready, 1);
    check("start_matrix_clear", matrix, 0);
    check("start_elem_count", elem_count, 0);
    check("start_dim_m", dim_m, mm);
    check("start_dim_n", dim_n, nn);
    held_m = 3'(mm); held_n = 3'(nn);
    while (k < total && !(stop_after >= 0 && k == stop_after)) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        m = 3'($urandom_range(1, 5)); n = 3'($urandom_range(1, 5)); start = 1'b1;
        step();
        start = 1'b0;
        check("gap_dim_m", dim_m, mm);
        check("gap_elem_count", elem_count, k);
        continue;
      end
      if (idx < vals.size()) v = vals[idx];
      else v = $urandom_range(0, 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
      idx++;
      bad = RC && (v > 9);
      elem_valid = 1'b1; elem_data = 8'(v);
      step();
      elem_valid = 1'b0;
      check("elem_err", err, bad);
      if (!bad) begin
        grid[k / nn][k % nn] = 8'(v);
        last_elem = 8'(v);
        k++;
      end
      check("elem_count", elem_count, k);
      check("mat_valid_timing", mat_valid, k == total);
    end
    packed_mat = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) packed_mat[(i * 5 + j) * 8 +: 8] = grid[i][j];
    if (k == total) begin
      e.mat = packed_mat; e.cnt = 5'(total); e.dm = 3'(mm); e.dn = 3'(nn);
      sb_q.push_back(e);
      held_mat = packed_mat;
    end
  endtask

  // Hold in DONE one cycle (with an ignored start), then hand the matrix over.
  task automatic release_matrix();
    m = 3'd1; n = 3'd1; start = 1'b1;
    step();
    start = 1'b0;
    check("done_hold_valid", mat_valid, 1);
    check("done_elem_ready", elem_ready, 0);
    check("done_hold_matrix", matrix, held_mat);
    mat_ready = 1'b1;
    step();
    mat_ready = 1'b0;
    check("release_mat_valid", mat_valid, 0);
    check("release_elem_ready", elem_ready, 0);
    check("release_matrix_kept", matrix, held_mat);
    check("release_dim_m_kept", dim_m, held_m);
  endtask

  task automatic bad_start(input int mm, input int nn);
    m = 3'(mm); n = 3'(nn); start = 1'b1;
    step();
    start = 1'b0;
    check("bad_start_err", err, 1);
    check("bad_start_elem_ready", elem_ready, 0);
    check("bad_start_matrix", matrix, held_mat);
    check("bad_start_dim_m", dim_m, held_m);
    check("bad_start_dim_n", dim_n, held_n);
    step();
    check("bad_start_err_width", err, 0);
    check("bad_start_idle", elem_ready, 0);
  endtask

  initial begin
    int none[$];
    int seq6[$];
    int seq25[$];
    int rc_vals[$];
    reset = 1'b1; m = '0; n = '0; start = 1'b0; abort = 1'b0;
    elem_valid = 1'b0; elem_data = '0; mat_ready = 1'b0;
    step();
    do_reset("reset");

    // 2x3 directed load
    seq6 = '{1, 2, 3, 4, 5, 6};
    run_load(2, 3, 1'b0, seq6, -1);
    check("dir_byte0", matrix[7:0], 1);
    check("dir_byte2", matrix[23:16], 3);
    check("dir_byte5", matrix[47:40], 4);
    check("dir_byte7", matrix[63:56], 6);
    check("dir_row0_pad", matrix[39:24], 0);
    check("dir_upper_zero", matrix[199:64], 0);
    release_matrix();

    // illegal dimensions
    bad_start(0, 3);
    bad_start(6, 2);
    bad_start(3, 7);

    // 5x5 with gaps
    for (int i = 0; i < 25; i++) seq25.push_back(i < 9 ? i + 1 : (i * 7) % 10);
    run_load(5, 5, 1'b1, seq25, -1);
    check("full_last_byte", matrix[199:192], last_elem);
    release_matrix();

    // abort after 3 elements of a 3x3, with an element offered in the abort cycle
    run_load(3, 3, 1'b0, none, 3);
    abort = 1'b1; elem_valid = 1'b1; elem_data = 8'd5;
    step();
    abort = 1'b0; elem_valid = 1'b0;
    check("abort_idle", elem_ready, 0);
    check("abort_matrix", matrix, 0);
    check("abort_elem_count", elem_count, 0);
    check("abort_err", err, 0);
    check("abort_mat_valid", mat_valid, 0);
    held_mat = '0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle_ignored", elem_ready, 0);
    run_load(1, 1, 1'b0, none, -1);
    release_matrix();

    // reset mid-LOAD and in DONE
    run_load(3, 3, 1'b0, none, 2);
    do_reset("reset_load");
    run_load(1, 2, 1'b0, none, -1);
    step();
    check("done_before_reset", mat_valid, 1);
    do_reset("reset_done");

    // range-check scenario: 1x2 fed 12, 7, 8
    rc_vals = '{12, 7, 8};
    run_load(1, 2, 1'b0, rc_vals, -1);
    check("rc_byte0", matrix[7:0], RC ? 7 : 12);
    check("rc_byte1", matrix[15:8], RC ? 8 : 7);
    release_matrix();

    // randomized loads
    for (int t = 0; t < 8; t++) begin
      run_load($urandom_range(1, 5), $urandom_range(1, 5), 1'(t % 2), none, -1);
      release_matrix();
      if (t == 3) bad_start(0, 0);
    end

    step();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_entry_loader.md
# matrix_entry_loader

Collects matrix elements one at a time from the user-input path and packs them row-major into the 200-bit, 5x5 by 8-bit matrix bus used by the matrix arithmetic units, including the scalar multiply unit. It sits directly upstream of those units. It latches the dimensions and counts row and column position. It presents the finished matrix with a valid/ready handshake.

## Interface
Parameters:
- MAX_DIM, 5: maximum rows and columns.
- ELEM_W, 8: element width in bits.
- MAX_ELEM, 9: largest legal element value; only used when range checking is compiled in.

Ports:
- clk, input, 1: single clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- m, input, 3: requested row count, sampled on start.
- n, input, 3: requested column count, sampled on start.
- start, input, 1: one-cycle pulse that begins a load.
- abort, input, 1: cancels a load in progress.
- elem_valid, input, 1: elem_data holds an element.
- elem_data, input, 8: element value.
- elem_ready, output, 1: loader accepts an element this cycle.
- mat_valid, output, 1: matrix complete and held stable.
- mat_ready, input, 1: consumer has taken the matrix.
- matrix, output, 200: packed matrix. Element (i,j) occupies bits [(i*5+j)*8 +: 8].
- dim_m, output, 3: latched row count.
- dim_n, output, 3: latched column count.
- elem_count, output, 5: number of elements accepted so far.
- err, output, 1: one-cycle error pulse.

## Operation
States are IDLE, LOAD and DONE.

- IDLE:
  - start with 1 <= m <= 5 and 1 <= n <= 5: latch dim_m/dim_n, clear matrix to 0, clear row, col and elem_count, go to LOAD.
  - start with m or n equal to 0 or greater than 5: pulse err for one cycle, stay in IDLE, leave matrix and dims unchanged.
- LOAD:
  - elem_ready = 1.
  - Acceptance: elem_valid && elem_ready. On acceptance, write elem_data to (row,col) and increment elem_count.
  - Column advance: col increments; when col == dim_n-1 it wraps to 0 and row increments.
  - Last element: accepting (dim_m-1, dim_n-1) moves to DONE.
  - Positions outside dim_m x dim_n stay 0.
- DONE:
  - mat_valid = 1; matrix, dim_m and dim_n are held stable.
  - mat_ready moves to IDLE. Matrix and dims keep their values until the next valid start.
- abort:
  - In LOAD: go to IDLE, clear matrix and elem_count, assert no err.
  - In IDLE or DONE: ignored.
- start in LOAD or DONE is ignored.
- abort has priority over elem_valid in the same cycle. The element is dropped.
- No arithmetic is performed. Element values are stored unmodified, 8 bits wide.

## Timing
- Reset values:
  - state = IDLE.
  - elem_ready, mat_valid and err = 0.
  - matrix = 0, dim_m = 0, dim_n = 0, elem_count = 0.
- Outputs are registered except elem_ready, which is decoded from state.
- An element accepted at edge k appears in matrix after edge k.
- mat_valid rises the cycle after the last element is accepted.
- Minimum load time: 1 cycle for start, then m*n cycles for elements, then mat_valid.
- mat_valid falls on the edge where mat_ready is sampled high.
- A new start is accepted, at the earliest, in the cycle after the return to IDLE.
- reset in any state, including mid-LOAD or in DONE, returns to the reset values on the next edge.
- err is exactly one cycle wide.

## Configuration
- ELEM_RANGE_CHECK_EN defined:
  - In LOAD, an element with elem_data > MAX_ELEM is not stored.
  - err pulses for one cycle; row, col and elem_count do not advance; the loader stays in LOAD.
- ELEM_RANGE_CHECK_EN undefined: every 8-bit value is accepted and err only reports bad dimensions.

## Structure
- Shared package:
  - Constants: MAX_DIM = 5, ELEM_W = 8, MAT_W = 200.
  - State typedef: IDLE / LOAD / DONE.
  - Element-offset function: (i*MAX_DIM + j)*ELEM_W.
- Sub-module rc_counter: row/column counter with clear, advance, a dim_n wrap input and a last-position flag.
- Everything else stays in matrix_entry_loader.

## Test plan
- m=2, n=3, start, then feed 1,2,3,4,5,6 back to back:
  - mat_valid rises 1 cycle after the 6th element.
  - matrix[7:0]=1, [23:16]=3, [47:40]=4, [63:56]=6, all other bytes 0.
  - elem_count = 6.
  - mat_ready clears mat_valid.
- m=0, n=3, start: err pulses for 1 cycle, state stays IDLE, elem_ready stays 0.
- m=5, n=5, feed 25 elements with elem_valid gaps: all 25 bytes land in order and matrix[199:192] holds the last element.
- Abort after 3 elements of a 3x3 load: IDLE next cycle, matrix = 0, elem_count = 0. A new 1x1 load then completes with a single element.
- reset asserted mid-LOAD and separately in DONE: all outputs return to reset values on the next edge.
- With ELEM_RANGE_CHECK_EN, 1x2 load, feed 12, then 7, then 8:
  - err pulses on 12 and 12 is dropped.
  - matrix[7:0]=7, matrix[15:8]=8.
  - Without the macro, 12 is stored.
